// File: rtl/multicycle_cpu_pkg.sv
// Shared MIPS types, decoder and ALU used by the multicycle core.
package multicycle_cpu_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  creg_addr_t;

   localparam word_t DEFAULT_RESET_PC = 32'hbfc0_0000;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} cpu_state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu;
      logic    a_shamt;
      logic    b_imm;
      logic    zext;
      logic    regwrite;
      logic    dst_rt;
      logic    link;
      logic    load;
      logic    store;
      logic    beq;
      logic    bne;
      logic    jump;
      logic    jr;
   } decoded_instr_t;

   function automatic decoded_instr_t decode(word_t ir);
      decoded_instr_t d;
      d = '0;
      case (ir[31:26])
         6'h00: begin
            d.regwrite = 1'b1;
            case (ir[5:0])
               6'h00: begin d.alu = ALU_SLL; d.a_shamt = 1'b1; end
               6'h02: begin d.alu = ALU_SRL; d.a_shamt = 1'b1; end
               6'h03: begin d.alu = ALU_SRA; d.a_shamt = 1'b1; end
               6'h04: d.alu = ALU_SLL;
               6'h06: d.alu = ALU_SRL;
               6'h07: d.alu = ALU_SRA;
               6'h08: begin d.regwrite = 1'b0; d.jr = 1'b1; end
               6'h21: d.alu = ALU_ADD;
               6'h23: d.alu = ALU_SUB;
               6'h24: d.alu = ALU_AND;
               6'h25: d.alu = ALU_OR;
               6'h26: d.alu = ALU_XOR;
               6'h27: d.alu = ALU_NOR;
               6'h2a: d.alu = ALU_SLT;
               6'h2b: d.alu = ALU_SLTU;
               default: d.regwrite = 1'b0;
            endcase
         end
         6'h02: d.jump = 1'b1;
         6'h03: begin d.jump = 1'b1; d.link = 1'b1; d.regwrite = 1'b1; end
         6'h04: d.beq = 1'b1;
         6'h05: d.bne = 1'b1;
         6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            d.b_imm = 1'b1;
            d.dst_rt = 1'b1;
            d.regwrite = 1'b1;
            case (ir[28:26])
               3'b001: d.alu = ALU_ADD;
               3'b010: d.alu = ALU_SLT;
               3'b011: d.alu = ALU_SLTU;
               3'b100: begin d.alu = ALU_AND; d.zext = 1'b1; end
               3'b101: begin d.alu = ALU_OR; d.zext = 1'b1; end
               3'b110: begin d.alu = ALU_XOR; d.zext = 1'b1; end
               default: d.alu = ALU_LUI;
            endcase
         end
         6'h23: begin
            d.b_imm = 1'b1; d.dst_rt = 1'b1;
            d.regwrite = 1'b1; d.load = 1'b1;
         end
         6'h2b: begin d.b_imm = 1'b1; d.store = 1'b1; end
         default: d = '0;
      endcase
      return d;
   endfunction

   // Shifts take the amount from a and shift b.
   function automatic word_t alu(alu_op_t op, word_t a, word_t b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'b0, a < b};
         ALU_SLL:  return b << a[4:0];
         ALU_SRL:  return b >> a[4:0];
         ALU_SRA:  return word_t'($signed(b) >>> a[4:0]);
         ALU_LUI:  return {b[15:0], 16'h0000};
         default:  return a + b;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_cpu_perf_counters.sv
// Free-running cycle counter and retired-instruction counter.
module perf_counters #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 retire,
   output logic [CNT_WIDTH-1:0] o_cycle_cnt,
   output logic [CNT_WIDTH-1:0] o_instret_cnt
);

   logic [CNT_WIDTH-1:0] r_cycle;
   logic [CNT_WIDTH-1:0] r_instret;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         r_cycle <= r_cycle + 1'b1;
         if (retire)
            r_instret <= r_instret + 1'b1;
      end
   end

   assign o_cycle_cnt   = r_cycle;
   assign o_instret_cnt = r_instret;

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS core: FETCH/EXEC/MEM/WB with req/ready memory ports.
module multicycle_cpu
   import multicycle_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_ready,
   input  logic [31:0]          imem_rdata,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [31:0]          dmem_addr,
   output logic [31:0]          dmem_wdata,
   input  logic                 dmem_ready,
   input  logic [31:0]          dmem_rdata,
   output logic [31:0]          debug_wb_pc,
   output logic [3:0]           debug_wb_rf_wen,
   output logic [4:0]           debug_wb_rf_wnum,
   output logic [31:0]          debug_wb_rf_wdata,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] instret_cnt
);

   cpu_state_t     r_state, w_next;
   word_t          r_pc, r_ir, r_aluout, r_npc, r_mdr;
   word_t          r_rf [32];
   decoded_instr_t w_dec;
   creg_addr_t     w_rs_n, w_rt_n, w_wnum;
   word_t          w_rs, w_rt, w_imm, w_a, w_b;
   word_t          w_pc4, w_npc, w_wdata;
   logic           w_taken, w_wb, w_wen, w_iacc, w_dacc;

   assign w_dec  = decode(r_ir);
   assign w_rs_n = r_ir[25:21];
   assign w_rt_n = r_ir[20:16];
   assign w_rs   = (w_rs_n == 5'd0) ? '0 : r_rf[w_rs_n];
   assign w_rt   = (w_rt_n == 5'd0) ? '0 : r_rf[w_rt_n];

   assign w_imm = w_dec.zext ? {16'h0000, r_ir[15:0]}
                             : {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_a   = w_dec.a_shamt ? {27'b0, r_ir[10:6]} : w_rs;
   assign w_b   = w_dec.b_imm ? w_imm : w_rt;
   assign w_pc4 = r_pc + 32'd4;

   assign w_taken = (w_dec.beq && (w_rs == w_rt))
                 || (w_dec.bne && (w_rs != w_rt));

   always_comb begin
      w_npc = w_pc4;
      unique case (1'b1)
         w_dec.jr:   w_npc = w_rs;
         w_dec.jump: w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
         w_taken:    w_npc = w_pc4 + {w_imm[29:0], 2'b00};
         default:    w_npc = w_pc4;
      endcase
   end

   assign w_wnum = w_dec.link   ? 5'd31
                 : w_dec.dst_rt ? w_rt_n
                 : r_ir[15:11];
   assign w_wdata = w_dec.load ? r_mdr : r_aluout;

   // Gating with resetn keeps every request and debug strobe low in reset.
   assign w_wb   = (r_state == WB) && resetn;
   assign w_wen  = w_wb && w_dec.regwrite && (w_wnum != 5'd0);
   assign w_iacc = imem_req && imem_ready;
   assign w_dacc = dmem_req && dmem_ready;

   assign imem_req   = (r_state == FETCH) && resetn;
   assign imem_addr  = r_pc;
   assign dmem_req   = (r_state == MEM) && resetn;
   assign dmem_we    = dmem_req && w_dec.store;
   assign dmem_addr  = r_aluout & 32'hffff_fffc;
   assign dmem_wdata = w_rt;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= FETCH;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH: if (w_iacc) w_next = EXEC;
         EXEC:  w_next = (w_dec.load || w_dec.store) ? MEM : WB;
         MEM:   if (w_dacc) w_next = WB;
         WB:    w_next = FETCH;
         default: w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_aluout <= '0;
         r_npc    <= '0;
         r_mdr    <= '0;
      end else begin
         if (r_state == FETCH && w_iacc)
            r_ir <= imem_rdata;
         if (r_state == EXEC) begin
            r_aluout <= w_dec.link ? r_pc + 32'd8
                                   : alu(w_dec.alu, w_a, w_b);
            r_npc    <= w_npc;
         end
         if (r_state == MEM && w_dacc && !w_dec.store)
            r_mdr <= dmem_rdata;
         if (r_state == WB)
            r_pc <= r_npc;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wen)
         r_rf[w_wnum] <= w_wdata;
   end

   assign debug_wb_pc       = w_wb ? r_pc : '0;
   assign debug_wb_rf_wen   = {4{w_wen}};
   assign debug_wb_rf_wnum  = w_wb ? w_wnum : '0;
   assign debug_wb_rf_wdata = w_wb ? w_wdata : '0;

   perf_counters #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf (
      .clk           (clk),
      .resetn        (resetn),
      .retire        (w_wb),
      .o_cycle_cnt   (cycle_cnt),
      .o_instret_cnt (instret_cnt)
   );

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu with variable-latency memory models.
module tb_multicycle_cpu;

   logic        clk = 1'b0;
   logic        resetn;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] wb_pc, wb_wdata;
   logic [3:0]  wb_wen;
   logic [4:0]  wb_wnum;
   logic [31:0] cyc_cnt, ret_cnt;

   logic        c4_ireq, c4_dreq, c4_dwe;
   logic [31:0] c4_iaddr, c4_daddr, c4_dwdata, c4_pc, c4_wdata;
   logic [3:0]  c4_wen;
   logic [4:0]  c4_wnum;
   logic [3:0]  c4_cyc, c4_ret;

   logic [31:0] imem [32];
   logic [31:0] dmem [64];
   logic [31:0] w_ioff;
   int          ilat, dlat, iw, dw, cyc;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   multicycle_cpu u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_ready        (dmem_ready),
      .dmem_rdata        (dmem_rdata),
      .debug_wb_pc       (wb_pc),
      .debug_wb_rf_wen   (wb_wen),
      .debug_wb_rf_wnum  (wb_wnum),
      .debug_wb_rf_wdata (wb_wdata),
      .cycle_cnt         (cyc_cnt),
      .instret_cnt       (ret_cnt)
   );

   multicycle_cpu #(.CNT_WIDTH(4)) u_c4 (
      .clk               (clk),
      .resetn            (resetn),
      .imem_req          (c4_ireq),
      .imem_addr         (c4_iaddr),
      .imem_ready        (1'b0),
      .imem_rdata        (32'h0),
      .dmem_req          (c4_dreq),
      .dmem_we           (c4_dwe),
      .dmem_addr         (c4_daddr),
      .dmem_wdata        (c4_dwdata),
      .dmem_ready        (1'b0),
      .dmem_rdata        (32'h0),
      .debug_wb_pc       (c4_pc),
      .debug_wb_rf_wen   (c4_wen),
      .debug_wb_rf_wnum  (c4_wnum),
      .debug_wb_rf_wdata (c4_wdata),
      .cycle_cnt         (c4_cyc),
      .instret_cnt       (c4_ret)
   );

   assign w_ioff     = imem_addr - 32'hbfc0_0000;
   assign imem_rdata = imem[w_ioff[6:2]];
   assign imem_ready = imem_req && (iw >= ilat);
   assign dmem_rdata = dmem[dmem_addr[7:2]];
   assign dmem_ready = dmem_req && (dw >= dlat);

   always @(posedge clk) begin
      cyc <= !resetn ? 1 : cyc + 1;
      iw  <= (!imem_req || imem_ready) ? 0 : iw + 1;
      dw  <= (!dmem_req || dmem_ready) ? 0 : dw + 1;
      if (dmem_req && dmem_ready && dmem_we)
         dmem[dmem_addr[7:2]] <= dmem_wdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wb(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (wb_pc === 32'h0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_wb_seen"}, 64'(n < 60), 64'd1);
   endtask

   task automatic wait_dreq(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (dmem_req !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_dreq_seen"}, 64'(n < 60), 64'd1);
   endtask

   initial begin
      foreach (imem[i]) imem[i] = 32'h0;
      foreach (dmem[i]) dmem[i] = 32'h0;
      imem[0]  = 32'h2401_0005; // addiu $1,$0,5
      imem[1]  = 32'h0021_1021; // addu $2,$1,$1
      imem[2]  = 32'hac01_0008; // sw $1,8($0)
      imem[3]  = 32'h8c03_0008; // lw $3,8($0)
      imem[4]  = 32'h1000_0002; // beq $0,$0,+2
      imem[5]  = 32'h2404_0001;
      imem[6]  = 32'h2404_0001;
      imem[7]  = 32'h1421_0005; // bne $1,$1,+5
      imem[8]  = 32'h0ff0_0010; // jal bfc00040
      imem[9]  = 32'h2404_0001;
      imem[10] = 32'h0001_2880; // sll $5,$1,2
      imem[11] = 32'hfc00_0000; // unknown opcode
      imem[12] = 32'h2400_0007; // addiu $0,$0,7
      imem[13] = 32'h0bf0_000d; // j bfc00034
      imem[16] = 32'h03e0_0008; // jr $31

      resetn = 1'b0;
      ilat = 0;
      dlat = 2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ireq", 64'(imem_req), 64'd0);
      chk("rst_dreq", 64'(dmem_req), 64'd0);
      chk("rst_dwe", 64'(dmem_we), 64'd0);
      chk("rst_iaddr", 64'(imem_addr), 64'hbfc0_0000);
      chk("rst_wen", 64'(wb_wen), 64'd0);
      chk("rst_wbpc", 64'(wb_pc), 64'd0);
      chk("rst_cyc", 64'(cyc_cnt), 64'd0);
      chk("rst_ret", 64'(ret_cnt), 64'd0);

      resetn = 1'b1;
      #1;
      chk("c1_ireq", 64'(imem_req), 64'd1);
      chk("c1_iaddr", 64'(imem_addr), 64'hbfc0_0000);

      wait_wb("addiu");
      chk("addiu_cyc", 64'(cyc), 64'd3);
      chk("addiu_pc", 64'(wb_pc), 64'hbfc0_0000);
      chk("addiu_wd", 64'(wb_wdata), 64'd5);
      chk("addiu_wn", 64'(wb_wnum), 64'd1);
      chk("addiu_wen", 64'(wb_wen), 64'hf);
      wait_wb("addu");
      chk("addu_cyc", 64'(cyc), 64'd6);
      chk("addu_pc", 64'(wb_pc), 64'hbfc0_0004);
      chk("addu_wd", 64'(wb_wdata), 64'd10);
      @(negedge clk);
      chk("c7_ret", 64'(ret_cnt), 64'd2);
      chk("c7_cyc", 64'(cyc_cnt), 64'd6);

      wait_dreq("sw");
      chk("sw_addr", 64'(dmem_addr), 64'd8);
      chk("sw_we", 64'(dmem_we), 64'd1);
      chk("sw_wdata", 64'(dmem_wdata), 64'd5);
      chk("sw_rdy0", 64'(dmem_ready), 64'd0);
      @(negedge clk);
      chk("sw_hold_req", 64'(dmem_req), 64'd1);
      chk("sw_hold_addr", 64'(dmem_addr), 64'd8);
      wait_wb("sw");
      chk("sw_pc", 64'(wb_pc), 64'hbfc0_0008);
      chk("sw_wen", 64'(wb_wen), 64'd0);
      chk("sw_mem", 64'(dmem[2]), 64'd5);

      wait_dreq("lw");
      chk("lw_we", 64'(dmem_we), 64'd0);
      chk("lw_addr", 64'(dmem_addr), 64'd8);
      wait_wb("lw");
      chk("lw_pc", 64'(wb_pc), 64'hbfc0_000c);
      chk("lw_wd", 64'(wb_wdata), 64'd5);
      chk("lw_wn", 64'(wb_wnum), 64'd3);
      chk("lw_wen", 64'(wb_wen), 64'hf);

      wait_wb("beq");
      chk("beq_pc", 64'(wb_pc), 64'hbfc0_0010);
      chk("beq_wen", 64'(wb_wen), 64'd0);
      wait_wb("bne");
      chk("bne_pc", 64'(wb_pc), 64'hbfc0_001c);
      wait_wb("jal");
      chk("jal_pc", 64'(wb_pc), 64'hbfc0_0020);
      chk("jal_wn", 64'(wb_wnum), 64'd31);
      chk("jal_wd", 64'(wb_wdata), 64'hbfc0_0028);
      chk("jal_wen", 64'(wb_wen), 64'hf);
      @(negedge clk);
      chk("jal_fetch", 64'(imem_addr), 64'hbfc0_0040);
      wait_wb("jr");
      chk("jr_pc", 64'(wb_pc), 64'hbfc0_0040);
      wait_wb("sll");
      chk("sll_pc", 64'(wb_pc), 64'hbfc0_0028);
      chk("sll_wd", 64'(wb_wdata), 64'd20);
      chk("sll_wn", 64'(wb_wnum), 64'd5);
      wait_wb("unk");
      chk("unk_pc", 64'(wb_pc), 64'hbfc0_002c);
      chk("unk_wen", 64'(wb_wen), 64'd0);
      wait_wb("r0");
      chk("r0_pc", 64'(wb_pc), 64'hbfc0_0030);
      chk("r0_wen", 64'(wb_wen), 64'd0);
      wait_wb("j1");
      chk("j1_pc", 64'(wb_pc), 64'hbfc0_0034);
      wait_wb("j2");
      chk("j2_pc", 64'(wb_pc), 64'hbfc0_0034);

      @(negedge clk);
      resetn = 1'b0;
      ilat = 3;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("st_req1", 64'(imem_req), 64'd1);
      chk("st_rdy1", 64'(imem_ready), 64'd0);
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         chk("st_req", 64'(imem_req), 64'd1);
         chk("st_addr", 64'(imem_addr), 64'hbfc0_0000);
         chk("st_rdy", 64'(imem_ready), 64'd0);
      end
      wait_wb("st");
      chk("st_cyc", 64'(cyc), 64'd6);
      chk("st_cnt", 64'(cyc_cnt), 64'd5);
      chk("st_wd", 64'(wb_wdata), 64'd5);

      ilat = 0;
      dlat = 50;
      wait_dreq("mr");
      @(negedge clk);
      @(negedge clk);
      chk("mr_stall", 64'(dmem_req), 64'd1);
      resetn = 1'b0;
      @(negedge clk);
      chk("mr_dreq", 64'(dmem_req), 64'd0);
      chk("mr_iaddr", 64'(imem_addr), 64'hbfc0_0000);
      chk("mr_cyc", 64'(cyc_cnt), 64'd0);
      chk("mr_ret", 64'(ret_cnt), 64'd0);
      dlat = 0;
      resetn = 1'b1;
      #1;
      chk("mr_ireq", 64'(imem_req), 64'd1);
      chk("mr_dreq2", 64'(dmem_req), 64'd0);

      repeat (15) @(negedge clk);
      chk("c4_15", 64'(c4_cyc), 64'd15);
      @(negedge clk);
      chk("c4_wrap", 64'(c4_cyc), 64'd0);
      chk("c32_16", 64'(cyc_cnt), 64'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
